// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and state encoding for the DDS sweep controller
package dds_pkg;

    // Default frequency-word width, matching the DDS f_word input
    localparam int FW_DEF = 26;

    // Sweep modes
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_TONE   = 2'b11;

    // Waveform selects understood by the DDS
    localparam logic [1:0] WAVE_SIN = 2'b00;
    localparam logic [1:0] WAVE_TRI = 2'b01;
    localparam logic [1:0] WAVE_SAW = 2'b10;
    localparam logic [1:0] WAVE_SQR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dds_step_calc.sv
// rtl/dds_step_calc.sv - combinational next frequency word with clamp to the stop value
//   cur    : current frequency word
//   stop   : endpoint being approached
//   step   : unsigned step magnitude
//   dir_up : 1 steps upward, 0 steps downward
//   next   : next frequency word, never beyond stop
module dds_step_calc
    import dds_pkg::*;
#(
    parameter int FW = FW_DEF
) (
    input  logic [FW-1:0] cur,
    input  logic [FW-1:0] stop,
    input  logic [FW-1:0] step,
    input  logic          dir_up,
    output logic [FW-1:0] next
);

    logic [FW:0] sum;
    logic [FW:0] lim;

    always_comb begin
        // One extra bit so a wrapped sum still compares above stop
        sum  = {1'b0, cur} + {1'b0, step};
        lim  = {1'b0, stop} + {1'b0, step};
        next = cur;
        if (dir_up) begin
            if (sum[FW] || (sum > {1'b0, stop})) begin
                next = stop;
            end else begin
                next = sum[FW-1:0];
            end
        end else begin
            // cur < stop + step means subtracting would pass (or wrap below) stop
            if ({1'b0, cur} < lim) begin
                next = stop;
            end else begin
                next = cur - step;
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency sweep sequencer driving the DDS control inputs
//   clk, rst           : clock, asynchronous active-high reset
//   cfg_valid/ready    : configuration handshake, accepted only when idle
//   cfg_*              : sweep configuration fields latched into shadow registers
//   start, abort       : single-cycle sweep control pulses
//   f_word, wave_c,
//   p_word, amplitude  : registered DDS control outputs
//   busy, seg_tick,
//   sweep_done         : sweep progress indicators
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic [1:0]    cfg_wave,
    input  logic [11:0]   cfg_p_word,
    input  logic [4:0]    cfg_amp,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] f_word,
    output logic [1:0]    wave_c,
    output logic [11:0]   p_word,
    output logic [4:0]    amplitude,
    output logic          busy,
    output logic          seg_tick,
    output logic          sweep_done
);

    state_t state;
    state_t state_nxt;

    // Shadow configuration
    logic [FW-1:0] sh_start;
    logic [FW-1:0] sh_stop;
    logic [FW-1:0] sh_step;
    logic [DW-1:0] sh_dwell;
    logic [1:0]    sh_mode;

    // Working endpoints; triangle mode swaps these at each turn
    logic [FW-1:0] run_start;
    logic [FW-1:0] run_stop;
    logic          dir_up;
    logic [DW-1:0] dwell_cnt;

    logic [FW-1:0] fwd_next;
    logic [FW-1:0] rev_next;
    logic          cfg_fire;
    logic          dwell_end;
    logic          at_end;
    logic          single_end;

    assign cfg_fire   = cfg_valid && (state == ST_IDLE);
    assign dwell_end  = (dwell_cnt == '0);
    assign at_end     = (f_word == run_stop);
    // A zero step never reaches stop, so single mode finishes after one dwell
    assign single_end = (sh_mode == MODE_SINGLE) && (at_end || (sh_step == '0));

    dds_step_calc #(.FW(FW)) u_fwd (
        .cur    (f_word),
        .stop   (run_stop),
        .step   (sh_step),
        .dir_up (dir_up),
        .next   (fwd_next)
    );

    // Step away from the endpoint just reached, toward the old start
    dds_step_calc #(.FW(FW)) u_rev (
        .cur    (f_word),
        .stop   (run_start),
        .step   (sh_step),
        .dir_up (~dir_up),
        .next   (rev_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        busy       = 1'b0;
        sweep_done = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (start && !abort) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if ((sh_mode != MODE_TONE) && dwell_end && single_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                sweep_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_dwell  <= DW'(1);
            sh_mode   <= MODE_SINGLE;
            run_start <= '0;
            run_stop  <= '0;
            dir_up    <= 1'b1;
            dwell_cnt <= '0;
            f_word    <= '0;
            wave_c    <= WAVE_SIN;
            p_word    <= '0;
            amplitude <= 5'd1;
            seg_tick  <= 1'b0;
        end else begin
            seg_tick <= 1'b0;
            if (cfg_fire) begin
                sh_start  <= cfg_f_start;
                sh_stop   <= cfg_f_stop;
                sh_step   <= cfg_f_step;
                sh_dwell  <= (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
                sh_mode   <= cfg_mode;
                wave_c    <= cfg_wave;
                p_word    <= cfg_p_word;
                amplitude <= (cfg_amp == 5'd0) ? 5'd1 : cfg_amp;
            end
            if ((state == ST_IDLE) && start && !abort) begin
                f_word    <= sh_start;
                run_start <= sh_start;
                run_stop  <= sh_stop;
                dir_up    <= (sh_start <= sh_stop);
                dwell_cnt <= sh_dwell - DW'(1);
            end else if ((state == ST_RUN) && !abort && (sh_mode != MODE_TONE)) begin
                if (!dwell_end) begin
                    dwell_cnt <= dwell_cnt - DW'(1);
                end else begin
                    dwell_cnt <= sh_dwell - DW'(1);
                    if (!at_end) begin
                        f_word   <= fwd_next;
                        seg_tick <= (fwd_next != f_word);
                    end else if (sh_mode == MODE_REPEAT) begin
                        f_word   <= run_start;
                        dir_up   <= (run_start <= run_stop);
                        seg_tick <= (run_start != f_word);
                    end else if (sh_mode == MODE_TRI) begin
                        run_start <= run_stop;
                        run_stop  <= run_start;
                        dir_up    <= ~dir_up;
                        f_word    <= rev_next;
                        seg_tick  <= (rev_next != f_word);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - scoreboard bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    localparam int FW = 26;
    localparam int DW = 24;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [FW-1:0] cfg_f_start;
    logic [FW-1:0] cfg_f_stop;
    logic [FW-1:0] cfg_f_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic [1:0]    cfg_wave;
    logic [11:0]   cfg_p_word;
    logic [4:0]    cfg_amp;
    logic          start;
    logic          abort;
    logic [FW-1:0] f_word;
    logic [1:0]    wave_c;
    logic [11:0]   p_word;
    logic [4:0]    amplitude;
    logic          busy;
    logic          seg_tick;
    logic          sweep_done;

    typedef struct {
        logic [FW-1:0] f;
        logic          busy;
        logic          tick;
        logic          done;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [FW-1:0] last_f;

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_f_step  (cfg_f_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .cfg_wave    (cfg_wave),
        .cfg_p_word  (cfg_p_word),
        .cfg_amp     (cfg_amp),
        .start       (start),
        .abort       (abort),
        .f_word      (f_word),
        .wave_c      (wave_c),
        .p_word      (p_word),
        .amplitude   (amplitude),
        .busy        (busy),
        .seg_tick    (seg_tick),
        .sweep_done  (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic longint step_to(input longint v, input longint e, input longint st);
        longint r;
        if (v <= e) r = (v + st > e) ? e : v + st;
        else        r = (v - st < e) ? e : v - st;
        return r;
    endfunction

    // Expected per-cycle outputs following the start edge
    task automatic model_push(input longint s, input longint e, input longint st,
                              input int dw, input int mode, input int ncyc);
        longint v, ps, pe, prev, tmp;
        int     d, n;
        bit     first;
        exp_t   it;
        sb_q.delete();
        d = (dw == 0) ? 1 : dw;
        ps = s; pe = e; v = s; prev = s; n = 0; first = 1'b1;
        if (mode == 3) begin
            for (int i = 0; i < ncyc; i++) begin
                it.f = FW'(s); it.busy = 1'b1; it.tick = 1'b0; it.done = 1'b0;
                sb_q.push_back(it);
            end
            return;
        end
        while (n < ncyc) begin
            for (int k = 0; k < d && n < ncyc; k++) begin
                it.f = FW'(v); it.busy = 1'b1; it.done = 1'b0;
                it.tick = (k == 0) && !first && (v != prev);
                sb_q.push_back(it);
                n++;
            end
            first = 1'b0;
            prev = v;
            if (mode == 0 && (v == pe || st == 0)) begin
                it.f = FW'(v); it.busy = 1'b0; it.tick = 1'b0; it.done = 1'b1;
                sb_q.push_back(it);
                it.done = 1'b0;
                sb_q.push_back(it);
                n = ncyc;
            end else if (v == pe && mode == 1) begin
                v = ps;
            end else if (v == pe && mode == 2) begin
                tmp = ps; ps = pe; pe = tmp;
                v = step_to(v, pe, st);
            end else begin
                v = step_to(v, pe, st);
            end
        end
    endtask

    // Pulse start, then pop and compare one scoreboard entry per cycle
    task automatic run_stream(input string tag);
        int   n;
        exp_t e;
        n = sb_q.size();
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            e = sb_q.pop_front();
            check({tag, "_f"},    32'(f_word),     32'(e.f));
            check({tag, "_busy"}, 32'(busy),       32'(e.busy));
            check({tag, "_tick"}, 32'(seg_tick),   32'(e.tick));
            check({tag, "_done"}, 32'(sweep_done), 32'(e.done));
            last_f = e.f;
        end
    endtask

    task automatic configure(input longint s, input longint e, input longint st, input int dw,
                             input logic [1:0] mode, input logic [1:0] wave,
                             input logic [11:0] pw, input logic [4:0] amp);
        int k;
        cfg_f_start = FW'(s);
        cfg_f_stop  = FW'(e);
        cfg_f_step  = FW'(st);
        cfg_dwell   = DW'(dw);
        cfg_mode    = mode;
        cfg_wave    = wave;
        cfg_p_word  = pw;
        cfg_amp     = amp;
        cfg_valid   = 1'b1;
        k = 0;
        while (!cfg_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!cfg_ready) begin
            check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
            cfg_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            check("cfg_wave", 32'(wave_c),    32'(wave));
            check("cfg_pw",   32'(p_word),    32'(pw));
            check("cfg_amp",  32'(amplitude), (amp == 5'd0) ? 32'd1 : 32'(amp));
        end
    endtask

    task automatic abort_check(input string tag);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_ready"}, 32'(cfg_ready),  32'd1);
        check({tag, "_hold"},  32'(f_word),     32'(last_f));
        check({tag, "_done"},  32'(sweep_done), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done2"}, 32'(sweep_done), 32'd0);
        check({tag, "_hold2"}, 32'(f_word),     32'(last_f));
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
        cfg_dwell = '0; cfg_mode = '0; cfg_wave = '0; cfg_p_word = '0; cfg_amp = '0;
        start = 1'b0; abort = 1'b0; last_f = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_f",     32'(f_word),     32'd0);
        check("rst_wave",  32'(wave_c),     32'd0);
        check("rst_pw",    32'(p_word),     32'd0);
        check("rst_amp",   32'(amplitude),  32'd1);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_tick",  32'(seg_tick),   32'd0);
        check("rst_done",  32'(sweep_done), 32'd0);
        check("rst_ready", 32'(cfg_ready),  32'd1);

        // Start on reset shadow values
        model_push(0, 0, 0, 1, 0, 1000);
        run_stream("noconf");

        // Zero amp and zero dwell are clamped to 1
        configure(5, 5, 0, 0, MODE_SINGLE, WAVE_SAW, 12'h123, 5'd0);
        model_push(5, 5, 0, 0, 0, 1000);
        run_stream("clamp01");

        configure(100, 130, 10, 3, MODE_SINGLE, WAVE_TRI, 12'h0aa, 5'd4);
        model_push(100, 130, 10, 3, 0, 1000);
        run_stream("single_up");

        configure(0, 25, 10, 1, MODE_SINGLE, WAVE_SIN, 12'h001, 5'd2);
        model_push(0, 25, 10, 1, 0, 1000);
        run_stream("clamp_stop");

        configure(67108859, 67108863, 8, 2, MODE_SINGLE, WAVE_SQR, 12'hfff, 5'd31);
        model_push(67108859, 67108863, 8, 2, 0, 1000);
        run_stream("ovf");

        configure(10, 50, 0, 4, MODE_SINGLE, WAVE_SIN, 12'h010, 5'd3);
        model_push(10, 50, 0, 4, 0, 1000);
        run_stream("step0");

        configure(50, 70, 10, 2, MODE_TRI, WAVE_TRI, 12'h222, 5'd5);
        model_push(50, 70, 10, 2, 2, 13);
        run_stream("tri");
        abort_check("tri_abort");

        configure(40, 10, 15, 2, MODE_REPEAT, WAVE_SAW, 12'h333, 5'd6);
        model_push(40, 10, 15, 2, 1, 15);
        run_stream("rep_dn");
        abort_check("rep_abort");

        // Fixed tone, then a config beat offered while busy must be refused
        configure(777, 900, 5, 3, MODE_TONE, WAVE_SQR, 12'h444, 5'd7);
        model_push(777, 900, 5, 3, 3, 6);
        run_stream("tone");
        cfg_f_start = FW'(1); cfg_wave = WAVE_SIN; cfg_p_word = 12'h555; cfg_amp = 5'd9;
        cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
            check("busy_cfg_wave",  32'(wave_c),    32'(WAVE_SQR));
            check("busy_cfg_pw",    32'(p_word),    32'h444);
            check("busy_cfg_amp",   32'(amplitude), 32'd7);
            check("tone_hold",      32'(f_word),    32'd777);
        end
        cfg_valid = 1'b0;
        abort_check("tone_abort");

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy",  32'(busy),      32'd0);
        check("sa_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        check("sa_busy2", 32'(busy),      32'd0);

        // Reset mid-sweep
        configure(100, 130, 10, 3, MODE_SINGLE, WAVE_SAW, 12'h0f0, 5'd12);
        model_push(100, 130, 10, 3, 0, 5);
        run_stream("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("mrst_f",     32'(f_word),     32'd0);
        check("mrst_wave",  32'(wave_c),     32'd0);
        check("mrst_pw",    32'(p_word),     32'd0);
        check("mrst_amp",   32'(amplitude),  32'd1);
        check("mrst_busy",  32'(busy),       32'd0);
        check("mrst_tick",  32'(seg_tick),   32'd0);
        check("mrst_done",  32'(sweep_done), 32'd0);
        check("mrst_ready", 32'(cfg_ready),  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(cfg_ready), 32'd1);
        check("post_rst_busy",  32'(busy),      32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
